// File: rtl/sram_bank_ctrl.sv
// Banked OpenRAM controller: one request at a time, SETUP/ACCESS/HOLD
// strobe sequencing with a registered response handshake.
module sram_bank_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int NUM_BANKS   = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [NUM_BANKS-1:0]        ram_csb,
  output logic                        ram_web,
  output logic                        ram_oeb,
  output logic [ADDR_W-$clog2(NUM_BANKS)-1:0] ram_addr,
  output logic [DATA_W-1:0]           ram_din,
  input  logic [NUM_BANKS*DATA_W-1:0] ram_dout
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IN_W   = ADDR_W - BANK_W;
  localparam int MAXC   = (WAIT_CYCLES > HOLD_CYCLES) ? WAIT_CYCLES : HOLD_CYCLES;
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int HOLD_LD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic [BANK_W-1:0]   bank_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [NUM_BANKS-1:0] ram_csb_q;
  logic                ram_web_q;
  logic                ram_oeb_q;
  logic [IN_W-1:0]     ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic [DATA_W-1:0]   bank_dout;

  assign bank_dout = ram_dout[int'(bank_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      bank_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_csb_q   <= '1;
      ram_web_q   <= 1'b1;
      ram_oeb_q   <= 1'b1;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            wr_q        <= req_write;
            bank_q      <= req_addr[ADDR_W-1 -: BANK_W];
            ram_addr_q  <= req_addr[IN_W-1:0];
            ram_din_q   <= req_wdata;
            ram_csb_q   <= ~(NUM_BANKS'(1) << req_addr[ADDR_W-1 -: BANK_W]);
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
          state_q <= S_ACCESS;
          if (wr_q) ram_web_q <= 1'b0;
          else      ram_oeb_q <= 1'b0;
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            ram_web_q   <= 1'b1;
            ram_oeb_q   <= 1'b1;
            rsp_rdata_q <= wr_q ? '0 : bank_dout;
            if (HOLD_CYCLES == 0) begin
              ram_csb_q   <= '1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              cnt_q   <= CNT_W'(HOLD_LD);
              state_q <= S_HOLD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            ram_csb_q   <= '1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_csb   = ram_csb_q;
  assign ram_web   = ram_web_q;
  assign ram_oeb   = ram_oeb_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl: default instance with a two-bank
// memory model, plus a WAIT_CYCLES=3 / HOLD_CYCLES=0 instance.
module tb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  ram_csb;
  logic        ram_web, ram_oeb;
  logic [10:0] ram_addr;
  logic [31:0] ram_din;
  logic [63:0] ram_dout;

  logic        req_valid2, req_ready2, req_write2;
  logic [11:0] req_addr2;
  logic [31:0] req_wdata2;
  logic        rsp_valid2, rsp_ready2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  ram_csb2;
  logic        ram_web2, ram_oeb2;
  logic [10:0] ram_addr2;
  logic [31:0] ram_din2;
  logic [63:0] ram_dout2;

  logic [31:0] mem [0:1][0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_csb(ram_csb), .ram_web(ram_web),
    .ram_oeb(ram_oeb), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  sram_bank_ctrl #(.WAIT_CYCLES(3), .HOLD_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2),
    .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_rdata(rsp_rdata2),
    .ram_csb(ram_csb2), .ram_web(ram_web2),
    .ram_oeb(ram_oeb2), .ram_addr(ram_addr2),
    .ram_din(ram_din2), .ram_dout(ram_dout2)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (!ram_csb[k] && !ram_web) mem[k][ram_addr] <= ram_din;
  end

  assign ram_dout  = {mem[1][ram_addr], mem[0][ram_addr]};
  assign ram_dout2 = {32'h0, (ram_addr2 == 11'h010) ? 32'hCAFEF00D : 32'h0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(
    input  logic        w,
    input  logic [11:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output int          lat,
    output int          web_n,
    output int          oeb_n,
    output int          csb_n,
    output logic [1:0]  csb_mask,
    output logic [10:0] s_addr,
    output logic [31:0] s_din,
    output int          viol
  );
    int t;
    rd = '0; lat = 0; web_n = 0; oeb_n = 0; csb_n = 0;
    csb_mask = '0; s_addr = '0; s_din = '0; viol = 0;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_write = ~w;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (lat == 1) begin
        s_addr = ram_addr;
        s_din  = ram_din;
      end
      if (!ram_web) web_n++;
      if (!ram_oeb) oeb_n++;
      if (ram_csb != 2'b11) csb_n++;
      csb_mask = csb_mask | ~ram_csb;
      if ((!ram_web && !ram_oeb) || ($countones(~ram_csb) > 1)) viol++;
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_mask;
    logic [10:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd, v;
    logic [1:0]  mask;
    logic [10:0] sa, exp_a;
    logic [31:0] sd;
    int lat, wn, on, cn, viol, t, accepts, since;

    #300000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v;
    logic [1:0]  mask;
    logic [10:0] sa, exp_a;
    logic [31:0] sd;
    int lat, wn, on, cn, viol, t, accepts, since;

    vecs[0] = '{1'b1, 12'h805, 32'hDEADBEEF, 32'h0,        2'b10, 11'h005};
    vecs[1] = '{1'b0, 12'h805, 32'h0,        32'hDEADBEEF, 2'b10, 11'h005};
    vecs[2] = '{1'b1, 12'h003, 32'h12345678, 32'h0,        2'b01, 11'h003};
    vecs[3] = '{1'b0, 12'h003, 32'h0,        32'h12345678, 2'b01, 11'h003};
    vecs[4] = '{1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h0,        2'b10, 11'h7FF};
    vecs[5] = '{1'b0, 12'hFFF, 32'h0,        32'hA5A5A5A5, 2'b10, 11'h7FF};
    vecs[6] = '{1'b0, 12'h805, 32'h0,        32'hDEADBEEF, 2'b10, 11'h005};
    vecs[7] = '{1'b0, 12'h003, 32'h0,        32'h12345678, 2'b01, 11'h003};

    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 0;
    req_valid2 = 0; req_write2 = 0; req_addr2 = '0; req_wdata2 = '0;
    rsp_ready2 = 0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_csb", {30'b0, ram_csb}, 32'h3);
    chk("rst_web", {31'b0, ram_web}, 32'h1);
    chk("rst_oeb", {31'b0, ram_oeb}, 32'h1);
    chk("rst_addr", {21'b0, ram_addr}, 32'h0);
    chk("rst_din", ram_din, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].w, vecs[i].a, vecs[i].wd,
              rd, lat, wn, on, cn, mask, sa, sd, viol);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_web_cycles", i), wn, vecs[i].w ? 1 : 0);
      chk($sformatf("v%0d_oeb_cycles", i), on, vecs[i].w ? 0 : 1);
      chk($sformatf("v%0d_csb_cycles", i), cn, 3);
      chk($sformatf("v%0d_csb_mask", i), {30'b0, mask},
          {30'b0, vecs[i].exp_mask});
      chk($sformatf("v%0d_ram_addr", i), {21'b0, sa},
          {21'b0, vecs[i].exp_addr});
      if (vecs[i].w)
        chk($sformatf("v%0d_ram_din", i), sd, vecs[i].wd);
      chk($sformatf("v%0d_strobe_viol", i), viol, 0);
    end

    // response stall: rsp_valid/rdata hold, no new request accepted
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_valid = 1; req_write = 0; req_addr = 12'h003;
    @(negedge clk);
    req_valid = 0;
    t = 0;
    while (!rsp_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), {31'b0, rsp_valid}, 32'h1);
      chk($sformatf("stall%0d_rdata", i), rsp_rdata, 32'h12345678);
      chk($sformatf("stall%0d_ready", i), {31'b0, req_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("stall_done_valid", {31'b0, rsp_valid}, 32'h0);
    chk("stall_done_ready", {31'b0, req_ready}, 32'h1);

    // req_valid held high with a new address every cycle
    rsp_ready = 1;
    accepts = 0;
    since = 99;
    exp_a = '0;
    for (int i = 0; i < 25; i++) begin
      since++;
      if (since >= 1 && since <= 3)
        chk($sformatf("stream%0d_addr", i), {21'b0, ram_addr},
            {21'b0, exp_a});
      req_valid = 1;
      req_write = 0;
      req_addr  = 12'(16 + i * 3);
      if (req_ready) begin
        accepts++;
        exp_a = req_addr[10:0];
        since = 0;
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("stream_accepts", accepts, 5);
    repeat (2) @(negedge clk);
    rsp_ready = 0;

    // reset during ACCESS of a write
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_valid = 1; req_write = 1; req_addr = 12'h100;
    req_wdata = 32'h11111111;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("abort_in_access_web", {31'b0, ram_web}, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("abort_csb", {30'b0, ram_csb}, 32'h3);
    chk("abort_web", {31'b0, ram_web}, 32'h1);
    chk("abort_oeb", {31'b0, ram_oeb}, 32'h1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    rst = 0;
    @(negedge clk);
    chk("abort_ready_back", {31'b0, req_ready}, 32'h1);
    run_txn(1'b1, 12'h101, 32'h22222222,
            rd, lat, wn, on, cn, mask, sa, sd, viol);
    chk("post_abort_wr_lat", lat, 4);
    chk("post_abort_wr_rdata", rd, 32'h0);
    run_txn(1'b0, 12'h101, 32'h0,
            rd, lat, wn, on, cn, mask, sa, sd, viol);
    chk("post_abort_rd_rdata", rd, 32'h22222222);

    // WAIT_CYCLES=3, HOLD_CYCLES=0 instance
    t = 0;
    while (!req_ready2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_valid2 = 1; req_write2 = 0; req_addr2 = 12'h010;
    @(negedge clk);
    req_valid2 = 0;
    lat = 1; on = 0; cn = 0;
    while (!rsp_valid2 && lat < 40) begin
      if (!ram_oeb2) on++;
      if (!ram_csb2[0]) cn++;
      @(negedge clk);
      lat++;
    end
    chk("w3_latency", lat, 5);
    chk("w3_oeb_cycles", on, 3);
    chk("w3_csb0_cycles", cn, 4);
    chk("w3_rdata", rsp_rdata2, 32'hCAFEF00D);
    rsp_ready2 = 1;
    @(negedge clk);
    rsp_ready2 = 0;
    chk("w3_done_ready", {31'b0, req_ready2}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
